// File: rtl/uart_rx_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer
//   UART receive front-end. Recovers 8N1 frames from the asynchronous serial
//   line, pushes every good byte into a first-word-fall-through FIFO that the
//   CPU drains, and keeps sticky framing-error / overrun flags for software.
//
// Ports
//   clk_in     in   system clock, all state on the rising edge
//   sys_rstn   in   asynchronous active-low reset
//   uart_rxd   in   serial input, idle high, asynchronous to clk_in
//   divisor    in   clk_in cycles per bit; values below 4 behave as 4
//   rd_en      in   pop the FIFO head (ignored while empty)
//   rd_data    out  FIFO head byte (fall-through, valid while !empty)
//   empty      out  FIFO holds no bytes
//   full       out  FIFO holds 2**FIFO_AW bytes
//   count      out  number of bytes held
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a good byte arrived while the FIFO was full
//   clr_err    in   clears both sticky flags (a same-cycle set wins)
//   irq        out  level interrupt, high while the FIFO is not empty
//   dbg_state  out  receiver FSM state (0 idle, 1 start, 2 data, 3 stop)
//
// Read handshake: empty acts as an inverted valid and rd_en as ready. A pop
// happens on any rising edge where rd_en is high and empty is low; rd_data
// shows the next entry from the following cycle. rd_en while empty is a
// no-op.
// ---------------------------------------------------------------------------
module uart_rx_buffer #(
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 16
) (
    input  logic               clk_in,
    input  logic               sys_rstn,
    input  logic               uart_rxd,
    input  logic [DIV_W-1:0]   divisor,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               clr_err,
    output logic               irq,
    output logic [1:0]         dbg_state
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronizer: both stages reset to the idle (high) line level so
    // that leaving reset never looks like a start edge.
    // -----------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver FSM and bit timer
    // -----------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] div_eff;
    logic             tick;
    logic             push_req;
    logic             set_fe;

    assign div_eff = (divisor < DIV_W'(4)) ? DIV_W'(4) : divisor;
    assign tick    = (cnt_q == '0);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_W'(4);
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        set_fe    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Divisor is latched here so a change mid-frame cannot skew
                // the bit timing. First tick lands in the middle of the start
                // bit.
                if (!rxs_q) begin
                    state_d = S_START;
                    div_d   = div_eff;
                    cnt_d   = (div_eff >> 1) - DIV_W'(1);
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        cnt_d     = div_q - DIV_W'(1);
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high: treat it as a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rxs_q, shift_q[7:1]};   // LSB first
                    cnt_d   = div_q - DIV_W'(1);
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rxs_q) begin
                        push_req = 1'b1;
                    end else begin
                        set_fe = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dbg_state = state_q;

    // -----------------------------------------------------------------------
    // FWFT FIFO
    // -----------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               push;
    logic               pop;
    logic               set_ov;

    assign empty = (count_q == '0);
    assign full  = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign pop   = rd_en && !empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign push   = push_req && (!full || pop);
    assign set_ov = push_req && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign irq     = !empty;

    // -----------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as clr_err wins.
    // -----------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    assign frame_err_d = set_fe || (frame_err_q && !clr_err);
    assign overrun_d   = set_ov || (overrun_q && !clr_err);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
